// File: rtl/ws2812_pkg.sv
// Shared timing constants and FSM state type for the WS2812 pixel serializer.
package ws2812_pkg;

    localparam int unsigned CYCLES_PER_BIT = 15;
    localparam int unsigned T0H_CYCLES     = 5;
    localparam int unsigned T1H_CYCLES     = 10;
    localparam int unsigned BITS_PER_PIXEL = 24;

    localparam int unsigned CELL_W = $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(BITS_PER_PIXEL);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TX,
        HOLD
    } state_t;

endpackage

// File: rtl/ws2812_bit_cell.sv
// One WS2812 bit cell: free-running cell counter while enabled and the
// high-time compare that decides the line level for the current cycle.
module ws2812_bit_cell
    import ws2812_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_val,
    output logic level,
    output logic cell_end
);

    logic [CELL_W-1:0] cell_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cell_cnt <= '0;
        end else if (cell_end) begin
            cell_cnt <= '0;
        end else begin
            cell_cnt <= cell_cnt + 1'b1;
        end
    end

    always_comb begin
        cell_end = en && (cell_cnt == CELL_W'(CYCLES_PER_BIT - 1));
        level    = en && (cell_cnt < (bit_val ? CELL_W'(T1H_CYCLES) : CELL_W'(T0H_CYCLES)));
    end

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 pixel serializer: GRB colour captured on load, shifted MSB first.
// Define WS2812_PROTO_ERR_EN to add the sticky protocol-error output err.
module ws2812_serializer
    import ws2812_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_sreg,
    input  logic       transmit_pixel,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       data_out,
    output logic       busy,
    output logic       pixel_done
`ifdef WS2812_PROTO_ERR_EN
    ,
    output logic       err
`endif
);

    state_t                    state;
    logic [BITS_PER_PIXEL-1:0] sreg;
    logic [BIT_W-1:0]          bit_cnt;
    logic                      tx_en;
    logic                      level;
    logic                      cell_end;
    logic                      last_cell;

    always_comb begin
        tx_en     = (state == TX);
        last_cell = cell_end && (bit_cnt == BIT_W'(BITS_PER_PIXEL - 1));
    end

    ws2812_bit_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .en       (tx_en),
        .bit_val  (sreg[BITS_PER_PIXEL-1]),
        .level    (level),
        .cell_end (cell_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            data_out   <= 1'b0;
            busy       <= 1'b0;
            pixel_done <= 1'b0;
        end else begin
            data_out   <= 1'b0;
            pixel_done <= 1'b0;
            unique case (state)
                IDLE, HOLD: begin
                    if (load_sreg) begin
                        sreg  <= {green, red, blue};
                        state <= ARMED;
                    end else if (state == HOLD && !transmit_pixel) begin
                        state <= IDLE;
                    end
                end
                ARMED: begin
                    if (load_sreg) begin
                        sreg <= {green, red, blue};
                    end
                    if (transmit_pixel) begin
                        state   <= TX;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                TX: begin
                    // The final cell completes even if the slot ends on the same
                    // cycle, so a 360-cycle transmit level yields a full pixel.
                    if (last_cell) begin
                        state      <= HOLD;
                        busy       <= 1'b0;
                        pixel_done <= 1'b1;
                    end else if (!transmit_pixel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        data_out <= level;
                        if (cell_end) begin
                            sreg    <= sreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WS2812_PROTO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == TX && load_sreg) ||
                     (state == IDLE && transmit_pixel) ||
                     (state == TX && !last_cell && !transmit_pixel)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_serializer.sv
// Self-checking bench for ws2812_serializer: expected outputs per clock edge
// are derived from the pixel timing rules and compared every cycle.
`timescale 1ns/1ps
module tb_ws2812_serializer;

    localparam int MAXC = 32768;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_sreg = 1'b0;
    logic       transmit_pixel = 1'b0;
    logic [7:0] red = '0;
    logic [7:0] green = '0;
    logic [7:0] blue = '0;
    logic       data_out;
    logic       busy;
    logic       pixel_done;
`ifdef WS2812_PROTO_ERR_EN
    logic       err;
`endif

    bit exp_data [MAXC];
    bit exp_busy [MAXC];
    bit exp_done [MAXC];
    bit exp_err  [MAXC];

    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    int hi_cnt = 0;
    int done_cnt = 0;

    ws2812_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .load_sreg      (load_sreg),
        .transmit_pixel (transmit_pixel),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .data_out       (data_out),
        .busy           (busy),
        .pixel_done     (pixel_done)
`ifdef WS2812_PROTO_ERR_EN
        ,
        .err            (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n = edge_n + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, req);
        end
    endtask

    // Line level k cycles after TX entry (k = 1..360) for colour word w.
    function automatic bit model_level(logic [23:0] w, int k);
        int b;
        int pos;
        if (k < 1 || k > 360) return 1'b0;
        b   = 23 - (k - 1) / 15;
        pos = (k - 1) % 15;
        return pos < (w[b] ? 10 : 5);
    endfunction

    always @(negedge clk) begin
        if (edge_n >= 1 && edge_n < MAXC) begin
            check("data_out", data_out, exp_data[edge_n]);
            check("busy", busy, exp_busy[edge_n]);
            check("pixel_done", pixel_done, exp_done[edge_n]);
`ifdef WS2812_PROTO_ERR_EN
            check("err", err, exp_err[edge_n]);
`endif
            if (data_out === 1'b1) hi_cnt++;
            if (pixel_done === 1'b1) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_err(int from, bit v);
        for (int i = from; i < MAXC; i++) exp_err[i] = v;
    endtask

    task automatic clear_from(int from);
        for (int i = from; i < from + 400 && i < MAXC; i++) begin
            exp_data[i] = 1'b0;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
        end
    endtask

    task automatic expect_pixel(int c0, logic [23:0] w);
        int idx;
        for (int k = 0; k <= 360; k++) begin
            idx = c0 + k;
            if (idx < MAXC) begin
                exp_busy[idx] = (k < 360);
                exp_done[idx] = (k == 360);
                exp_data[idx] = model_level(w, k);
            end
        end
    endtask

    task automatic do_reset();
        int r;
        rst = 1'b1;
        transmit_pixel = 1'b0;
        load_sreg = 1'b0;
        r = edge_n + 1;
        step();
        clear_from(r);
        fill_err(r, 1'b0);
        rst = 1'b0;
    endtask

    task automatic do_load(logic [23:0] w);
        green = w[23:16];
        red   = w[15:8];
        blue  = w[7:0];
        load_sreg = 1'b1;
        step();
        load_sreg = 1'b0;
        {green, red, blue} = 24'($urandom);
    endtask

    // One load + transmit slot; k-indexed events are sampled at TX entry edge + k.
    task automatic run_pixel(logic [23:0] w, int abort_k, int load_k, int rst_k, int hold_extra);
        int c0;
        do_load(w);
        transmit_pixel = 1'b1;
        c0 = edge_n + 1;
        expect_pixel(c0, w);
        step();
        for (int k = 1; k <= 360; k++) begin
            if (k == 360 && hold_extra == 0) transmit_pixel = 1'b0;
            if (k == abort_k) transmit_pixel = 1'b0;
            if (k == load_k) begin
                blue = 8'hAA;
                load_sreg = 1'b1;
            end
            if (k == rst_k) begin
                rst = 1'b1;
                transmit_pixel = 1'b0;
            end
            step();
            load_sreg = 1'b0;
            if (k == load_k) fill_err(c0 + k, 1'b1);
            if (k == abort_k) begin
                clear_from(c0 + k);
                fill_err(c0 + k, 1'b1);
                break;
            end
            if (k == rst_k) begin
                clear_from(c0 + k);
                fill_err(c0 + k, 1'b0);
                rst = 1'b0;
                step();
                break;
            end
        end
        if (hold_extra > 0) begin
            repeat (hold_extra) step();
            transmit_pixel = 1'b0;
            step();
        end
    endtask

    initial begin
        int e;
        logic [23:0] w;

        step();
        step();
        rst = 1'b0;
        check("reset_data_out", data_out, 1'b0);
        check("reset_busy", busy, 1'b0);

        check("model_1bit_k1", model_level(24'hFF0000, 1), 1'b1);
        check("model_1bit_k10", model_level(24'hFF0000, 10), 1'b1);
        check("model_1bit_k11", model_level(24'hFF0000, 11), 1'b0);
        check("model_0bit_k125", model_level(24'hFF0000, 125), 1'b1);
        check("model_0bit_k126", model_level(24'hFF0000, 126), 1'b0);
        check("model_last_k360", model_level(24'hFFFFFF, 360), 1'b0);

        hi_cnt = 0;
        done_cnt = 0;
        run_pixel(24'hFF0000, -1, -1, -1, 0);
        step();
        check("g_ff_high_cycles", hi_cnt, 160);
        check("g_ff_done_pulses", done_cnt, 1);

        hi_cnt = 0;
        done_cnt = 0;
        run_pixel(24'h000000, -1, -1, -1, 20);
        check("black_high_cycles", hi_cnt, 120);
        check("black_done_pulses", done_cnt, 1);

        // Second load in ARMED must win.
        do_load(24'($urandom));
        run_pixel(24'($urandom), -1, -1, -1, 0);
        step();

        transmit_pixel = 1'b1;
        e = edge_n + 1;
        fill_err(e, 1'b1);
        repeat (5) step();
        transmit_pixel = 1'b0;
        step();
        do_reset();

        done_cnt = 0;
        run_pixel(24'($urandom), 100, -1, -1, 0);
        repeat (5) step();
        check("abort_no_done", done_cnt, 0);
        do_reset();

        run_pixel(24'($urandom), -1, 50, -1, 0);
        step();
        do_reset();

        run_pixel(24'($urandom), -1, -1, 200, 0);
        check("rst_mid_tx_busy", busy, 1'b0);
        run_pixel(24'($urandom), -1, -1, -1, 0);
        step();
        do_reset();

        done_cnt = 0;
        for (int p = 0; p < 64; p++) begin
            w = 24'($urandom);
            run_pixel(w, -1, -1, -1, 0);
        end
        step();
        check("b2b_done_pulses", done_cnt, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_serializer.md
WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port: load_sreg  in  1  capture colour into shift register.
REQ-004 SHALL have port: transmit_pixel  in  1  level, high for the whole pixel slot (360 cycles).
REQ-005 SHALL have ports: red, green, blue  in  8 each  colour of current pixel.
REQ-006 SHALL have port: data_out  out  1  registered WS2812 line drive.
REQ-007 SHALL have port: busy  out  1  high while in TX.
REQ-008 SHALL have port: pixel_done  out  1  one-cycle pulse after 24th bit cell.
REQ-009 SHALL have port (macro only): err  out  1  sticky protocol-error flag.

Function
REQ-010 SHALL implement states IDLE, ARMED, TX, HOLD.
REQ-011 SHALL, on a load_sreg rising-edge sample in IDLE or HOLD, capture sreg = {green, red, blue} (GRB, MSB first) and go to ARMED.
REQ-012 SHALL, in ARMED with transmit_pixel sampled high, go to TX with cell_cnt=0, bit_cnt=0.
REQ-013 SHALL use cell_cnt 0..14 (CYCLES_PER_BIT=15); at 14 it wraps to 0, shifts sreg left by one, and increments bit_cnt.
REQ-014 SHALL register data_out = 1 for cell_cnt < T1H_CYCLES (10) when sreg[23]=1, cell_cnt < T0H_CYCLES (5) when 0, else 0; one-cycle latency from cell_cnt to pin.
REQ-015 SHALL, on cell_cnt=14 with bit_cnt=23, pulse pixel_done the next cycle and go to HOLD (data_out 0).
REQ-016 SHALL make one pixel exactly 360 cycles, 24*15, from TX entry to pixel_done.
REQ-017 SHALL, in HOLD, keep data_out 0 until transmit_pixel low, then go to IDLE; a load_sreg in HOLD is accepted per REQ-011.
REQ-018 SHALL, when transmit_pixel falls during TX, abort: data_out 0 next cycle, state IDLE, no pixel_done.
REQ-019 SHALL ignore load_sreg while in TX; sreg remains unchanged.
REQ-020 SHALL ignore transmit_pixel while in IDLE; data_out stays 0.
REQ-021 SHALL make a load_sreg in ARMED re-capture colour, last load wins.

Reset
REQ-022 SHALL, when rst is sampled high, set state IDLE, sreg 0, cell_cnt 0, bit_cnt 0, data_out 0, busy 0, pixel_done 0, err 0 on the next edge, including mid-TX; rst has priority over all inputs.

Configuration
REQ-023 SHALL, with WS2812_PROTO_ERR_EN defined, set err sticky on: load_sreg in TX, transmit_pixel high in IDLE, or abort per REQ-018; err clears only on rst.
REQ-024 SHALL, without WS2812_PROTO_ERR_EN, omit the err port and logic; all other behaviour is identical.

Structure
REQ-025 SHALL place CYCLES_PER_BIT=15, T0H_CYCLES=5, T1H_CYCLES=10, BITS_PER_PIXEL=24 and the state enum in package ws2812_pkg.
REQ-026 SHALL put the cell counter and high-time compare in sub-module ws2812_bit_cell (inputs bit value/enable; outputs level, cell_end).

Verification
REQ-027 SHALL test: G=FF R=00 B=00, load then transmit 360 cycles -> 8 pulses of 10 high/5 low, then 16 pulses of 5 high/10 low, pixel_done at cycle 360.
REQ-028 SHALL test: G=R=B=00 -> 24 pulses of 5 high, data_out 0 in HOLD until transmit_pixel low.
REQ-029 SHALL test: transmit_pixel falls at cycle 100 of TX -> data_out 0 at 101, state IDLE, no pixel_done, err=1 with macro.
REQ-030 SHALL test: load_sreg with B=AA pulsed at TX cycle 50 -> waveform unchanged from first colour, err=1 with macro.
REQ-031 SHALL test: rst at TX cycle 200 -> all outputs 0 next cycle; a fresh load+transmit then produces a correct 360-cycle pixel.
REQ-032 SHALL test: 64 back-to-back pixels with controller-style phasing (load, then 360-cycle transmit) -> 64 pixel_done pulses, no err.
